uart_cmd_decoder: RTL

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: parses A5/ADDR/DATA/CHK packets into threshold
// registers and queues a one-byte ACK/NAK reply for the UART transmitter.
//
// state   | meaning
// IDLE    | hunting for the 0xA5 sync byte
// ADDR    | expecting the register address
// DATA_HI | expecting the high data byte (16-bit solar_th only)
// DATA_LO | expecting the low (or only) data byte
// CHK     | expecting the XOR checksum; commit or reject on arrival
module uart_cmd_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       ack_ready,
  output logic [7:0] ack_data,
  output logic       ack_valid,
  output logic [15:0] solar_th,
  output logic [7:0] solar_cooldown_th,
  output logic [7:0] solar_heatup_th,
  output logic [7:0] ambient_cooldown_th,
  output logic [7:0] ambient_heatup_th,
  output logic [7:0] geothermal_cooldown_th,
  output logic [7:0] geothermal_heatup_th,
  output logic       cfg_update
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA_HI, DATA_LO, CHK} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [TW-1:0] r_tmo;
  logic [2:0]  r_addr;
  logic [15:0] r_shadow;
  logic [7:0]  r_xor;
  logic [15:0] r_solar_th;
  logic [7:0]  r_th [0:5];
  logic        r_ack_valid;
  logic [7:0]  r_ack_data;
  logic        r_cfg_update;

  logic        w_timeout;
  logic        w_reply_load;
  logic [7:0]  w_reply_byte;
  logic        w_write;

  assign w_timeout = (r_state != IDLE) && !rx_valid && (r_tmo == TMO_LAST);

  always_comb begin
    w_state_next = r_state;
    w_reply_load = 1'b0;
    w_reply_byte = 8'h00;
    w_write      = 1'b0;
    if (rx_valid) begin
      case (r_state)
        IDLE:    if (rx_data == SYNC_BYTE) w_state_next = ADDR;
        ADDR: begin
          if (rx_data == 8'h00) begin
            w_state_next = DATA_HI;
          end else if (rx_data <= 8'h06) begin
            w_state_next = DATA_LO;
          end else begin
            w_state_next = IDLE;
            w_reply_load = 1'b1;
            w_reply_byte = NAK_BYTE;
          end
        end
        DATA_HI: w_state_next = DATA_LO;
        DATA_LO: w_state_next = CHK;
        CHK: begin
          w_state_next = IDLE;
          w_reply_load = 1'b1;
          if (rx_data == r_xor) begin
            w_write      = 1'b1;
            w_reply_byte = 8'h80 | {5'b0, r_addr};
          end else begin
            w_reply_byte = NAK_BYTE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo        <= '0;
      r_addr       <= 3'd0;
      r_shadow     <= 16'h0000;
      r_xor        <= 8'h00;
      r_solar_th   <= 16'h0200;
      for (int i = 0; i < 6; i++) r_th[i] <= (i % 2 == 0) ? 8'h03 : 8'hFD;
      r_ack_valid  <= 1'b0;
      r_ack_data   <= 8'h00;
      r_cfg_update <= 1'b0;
    end else begin
      r_cfg_update <= w_write;

      if (rx_valid || r_state == IDLE || w_timeout) r_tmo <= '0;
      else                                          r_tmo <= r_tmo + 1'b1;

      // running XOR is seeded by ADDR so CHK compares against one register
      if (rx_valid) begin
        case (r_state)
          ADDR: begin
            r_addr <= rx_data[2:0];
            r_xor  <= rx_data;
          end
          DATA_HI: begin
            r_shadow[15:8] <= rx_data;
            r_xor          <= r_xor ^ rx_data;
          end
          DATA_LO: begin
            r_shadow[7:0] <= rx_data;
            r_xor         <= r_xor ^ rx_data;
          end
          default: ;
        endcase
      end

      if (w_write) begin
        if (r_addr == 3'd0) r_solar_th <= r_shadow;
        else                r_th[r_addr - 3'd1] <= r_shadow[7:0];
      end

      if (w_reply_load) begin
        r_ack_valid <= 1'b1;
        r_ack_data  <= w_reply_byte;
      end else if (r_ack_valid && ack_ready) begin
        r_ack_valid <= 1'b0;
      end
    end
  end

  assign ack_valid              = r_ack_valid;
  assign ack_data               = r_ack_data;
  assign cfg_update             = r_cfg_update;
  assign solar_th               = r_solar_th;
  assign solar_cooldown_th      = r_th[0];
  assign solar_heatup_th        = r_th[1];
  assign ambient_cooldown_th    = r_th[2];
  assign ambient_heatup_th      = r_th[3];
  assign geothermal_cooldown_th = r_th[4];
  assign geothermal_heatup_th   = r_th[5];

endmodule
